// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Optional MDU_EARLY_OUT_EN: multiplies stop once the remaining multiplier is zero.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         state;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] acc;

    logic               rs_neg;
    logic               rt_neg;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;

    logic [2*WIDTH-1:0] a_nxt;
    logic [WIDTH-1:0]   b_nxt;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH:0]     sh;
    logic [WIDTH:0]     diff;
    logic               q_bit;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;

    logic               early;
    logic               run_exit;

    // op[0]=1 selects the unsigned variants, which take raw operands
    assign rs_neg = ~op[0] & rs_data[WIDTH-1];
    assign rt_neg = ~op[0] & rt_data[WIDTH-1];
    assign rs_mag = rs_neg ? -rs_data : rs_data;
    assign rt_mag = rt_neg ? -rt_data : rt_data;

    // Multiply: a_reg is the shifting multiplicand, b_reg the multiplier,
    // acc the product. Divide: a_reg[W-1:0] shifts dividend out and
    // quotient in, b_reg is the divisor, acc[W-1:0] the partial remainder.
    always_comb begin
        a_nxt   = a_reg;
        b_nxt   = b_reg;
        acc_nxt = acc;
        sh      = '0;
        diff    = '0;
        q_bit   = 1'b0;
        if (is_div) begin
            sh      = {acc[WIDTH-1:0], a_reg[WIDTH-1]};
            diff    = sh - {1'b0, b_reg};
            q_bit   = ~diff[WIDTH];
            acc_nxt = {{WIDTH{1'b0}}, (q_bit ? diff[WIDTH-1:0] : sh[WIDTH-1:0])};
            a_nxt   = {{WIDTH{1'b0}}, a_reg[WIDTH-2:0], q_bit};
        end else begin
            if (b_reg[0]) begin
                acc_nxt = acc + a_reg;
            end
            a_nxt = a_reg << 1;
            b_nxt = b_reg >> 1;
        end
    end

`ifdef MDU_EARLY_OUT_EN
    assign early = ~is_div & (b_nxt == '0);
`else
    assign early = 1'b0;
`endif

    assign run_exit = (cnt == LAST) | early;

    always_comb begin
        prod   = neg_q ? -acc : acc;
        quo    = a_reg[WIDTH-1:0];
        rem    = acc[WIDTH-1:0];
        hi_fix = prod[2*WIDTH-1:WIDTH];
        lo_fix = prod[WIDTH-1:0];
        if (is_div) begin
            hi_fix = neg_r ? -rem : rem;
            lo_fix = div_zero ? '1 : (neg_q ? -quo : quo);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_RUN;
                        is_div   <= op[1];
                        neg_q    <= rs_neg ^ rt_neg;
                        neg_r    <= rs_neg;
                        div_zero <= (rt_data == '0);
                        cnt      <= '0;
                        a_reg    <= {{WIDTH{1'b0}}, rs_mag};
                        b_reg    <= rt_mag;
                        acc      <= '0;
                    end else begin
                        if (mthi) hi <= rs_data;
                        if (mtlo) lo <= rs_data;
                    end
                end
                S_RUN: begin
                    a_reg <= a_nxt;
                    b_reg <= b_nxt;
                    acc   <= acc_nxt;
                    cnt   <= cnt + 1'b1;
                    if (run_exit) state <= S_FIX;
                end
                S_FIX: begin
                    hi    <= hi_fix;
                    lo    <= lo_fix;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule
